// File: rtl/input_debouncer.sv
// Debounces WIDTH button/switch inputs: a two-flop synchroniser, a shared sample-tick prescaler,
// and per-channel consecutive-sample counters producing clean levels plus press/release pulses.
module input_debouncer #(
    parameter int WIDTH        = 16,
    parameter int DIV_BITS     = 4,
    parameter int STABLE_COUNT = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] raw,
    output logic [WIDTH-1:0] stable,
    output logic [WIDTH-1:0] pressed,
    output logic [WIDTH-1:0] released,
    output logic             any_event
);

    localparam int CNT_W = $clog2(STABLE_COUNT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_COUNT - 1);

    logic [WIDTH-1:0]    sync1_q;
    logic [WIDTH-1:0]    sync2_q;
    logic [DIV_BITS-1:0] div_q;
    logic [CNT_W-1:0]    cnt_q [WIDTH];
    logic [CNT_W-1:0]    cnt_d [WIDTH];
    logic [WIDTH-1:0]    stable_q,   stable_d;
    logic [WIDTH-1:0]    pressed_q,  pressed_d;
    logic [WIDTH-1:0]    released_q, released_d;
    logic                any_event_q, any_event_d;
    logic                tick;

    // div resets to 0, so the very first edge after reset is a sample tick
    assign tick = (div_q == '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            div_q       <= '0;
            stable_q    <= '0;
            pressed_q   <= '0;
            released_q  <= '0;
            any_event_q <= 1'b0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q     <= raw;
            sync2_q     <= sync1_q;
            div_q       <= div_q + 1'b1;
            stable_q    <= stable_d;
            pressed_q   <= pressed_d;
            released_q  <= released_d;
            any_event_q <= any_event_d;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // A single sample that agrees with the clean level restarts that channel's count
    always_comb begin
        stable_d   = stable_q;
        pressed_d  = '0;
        released_d = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = cnt_q[i];
        end
        if (tick) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (sync2_q[i] != stable_q[i]) begin
                    if (cnt_q[i] == CNT_LAST) begin
                        stable_d[i]   = sync2_q[i];
                        pressed_d[i]  = sync2_q[i];
                        released_d[i] = ~sync2_q[i];
                        cnt_d[i]      = '0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_W'(1);
                    end
                end else begin
                    cnt_d[i] = '0;
                end
            end
        end
        any_event_d = |(pressed_d | released_d);
    end

    assign stable    = stable_q;
    assign pressed   = pressed_q;
    assign released  = released_q;
    assign any_event = any_event_q;

endmodule

// File: tb/tb_input_debouncer.sv
// Directed table-driven bench for input_debouncer with WIDTH=16, DIV_BITS=2, STABLE_COUNT=3
// (sample ticks on edges 1, 5, 9, 13, ... after reset release).
module tb_input_debouncer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] raw;
    logic [15:0] stable;
    logic [15:0] pressed;
    logic [15:0] released;
    logic        any_event;

    int checks = 0;
    int errors = 0;

    input_debouncer #(
        .WIDTH(16),
        .DIV_BITS(2),
        .STABLE_COUNT(3)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .raw(raw),
        .stable(stable),
        .pressed(pressed),
        .released(released),
        .any_event(any_event)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] raw;
        int          ncyc;
        logic [15:0] st;
        logic [15:0] pr;
        logic [15:0] rl;
        logic        ev;
    } vec_t;

    localparam int NV = 17;
    vec_t vecs [NV];

    function automatic vec_t mk(logic [15:0] r, int n, logic [15:0] s,
                                logic [15:0] p, logic [15:0] l, logic e);
        vec_t v;
        v.raw = r; v.ncyc = n; v.st = s; v.pr = p; v.rl = l; v.ev = e;
        return v;
    endfunction

    task automatic check(input string tag, input logic [15:0] s, input logic [15:0] p,
                         input logic [15:0] l, input logic e);
        checks += 4;
        if (stable !== s) begin
            errors++;
            $display("FAIL %s stable got %h expected %h at %0t", tag, stable, s, $time);
        end
        if (pressed !== p) begin
            errors++;
            $display("FAIL %s pressed got %h expected %h at %0t", tag, pressed, p, $time);
        end
        if (released !== l) begin
            errors++;
            $display("FAIL %s released got %h expected %h at %0t", tag, released, l, $time);
        end
        if (any_event !== e) begin
            errors++;
            $display("FAIL %s any_event got %b expected %b at %0t", tag, any_event, e, $time);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout checks %0d errors %0d", checks, errors);
        $fatal(1, "timeout");
    end

    initial begin
        // Edge numbers relative to reset release; ticks at 1,5,9,...
        vecs[0]  = mk(16'h0001, 12, 16'h0000, 16'h0000, 16'h0000, 1'b0); // press, edges 1..12
        vecs[1]  = mk(16'h0001,  1, 16'h0001, 16'h0001, 16'h0000, 1'b1); // edge 13
        vecs[2]  = mk(16'h0001,  1, 16'h0001, 16'h0000, 16'h0000, 1'b0); // edge 14
        vecs[3]  = mk(16'h0009,  6, 16'h0001, 16'h0000, 16'h0000, 1'b0); // glitch 15..20
        vecs[4]  = mk(16'h0001, 10, 16'h0001, 16'h0000, 16'h0000, 1'b0); // 21..30
        vecs[5]  = mk(16'h0021,  8, 16'h0001, 16'h0000, 16'h0000, 1'b0); // ticks 33,37
        vecs[6]  = mk(16'h0001,  4, 16'h0001, 16'h0000, 16'h0000, 1'b0); // tick 41 sees 0
        vecs[7]  = mk(16'h0021, 10, 16'h0001, 16'h0000, 16'h0000, 1'b0); // ticks 45,49
        vecs[8]  = mk(16'h0021,  1, 16'h0021, 16'h0020, 16'h0000, 1'b1); // edge 53
        vecs[9]  = mk(16'h0021,  1, 16'h0021, 16'h0000, 16'h0000, 1'b0); // edge 54
        vecs[10] = mk(16'h00F0, 10, 16'h0021, 16'h0000, 16'h0000, 1'b0); // 55..64
        vecs[11] = mk(16'h00F0,  1, 16'h00F0, 16'h00D0, 16'h0001, 1'b1); // edge 65
        vecs[12] = mk(16'h00F0,  1, 16'h00F0, 16'h0000, 16'h0000, 1'b0); // edge 66
        vecs[13] = mk(16'h000F, 10, 16'h00F0, 16'h0000, 16'h0000, 1'b0); // 67..76
        vecs[14] = mk(16'h000F,  1, 16'h000F, 16'h000F, 16'h00F0, 1'b1); // edge 77
        vecs[15] = mk(16'h000F,  1, 16'h000F, 16'h0000, 16'h0000, 1'b0); // edge 78
        vecs[16] = mk(16'h008F,  8, 16'h000F, 16'h0000, 16'h0000, 1'b0); // 79..86, cnt[7]=2

        reset_n = 1'b0;
        raw     = 16'hFFFF;
        repeat (10) begin
            @(posedge clk); #1;
            check("reset_hold", 16'h0000, 16'h0000, 16'h0000, 1'b0);
        end

        raw     = 16'h0001;
        reset_n = 1'b1;

        for (int v = 0; v < NV; v++) begin
            raw = vecs[v].raw;
            for (int c = 0; c < vecs[v].ncyc; c++) begin
                @(posedge clk); #1;
                check($sformatf("vec%0d_cyc%0d", v, c), vecs[v].st, vecs[v].pr,
                      vecs[v].rl, vecs[v].ev);
            end
        end

        // Reset mid-count: asserted between edges, outputs must clear without a clock
        #3;
        reset_n = 1'b0;
        #1;
        check("rst_async", 16'h0000, 16'h0000, 16'h0000, 1'b0);
        raw = 16'h0080;
        repeat (3) begin
            @(posedge clk); #1;
            check("rst_held", 16'h0000, 16'h0000, 16'h0000, 1'b0);
        end
        reset_n = 1'b1;
        for (int e = 1; e <= 12; e++) begin
            @(posedge clk); #1;
            check($sformatf("rst_recount_e%0d", e), 16'h0000, 16'h0000, 16'h0000, 1'b0);
        end
        @(posedge clk); #1;
        check("rst_rise_e13", 16'h0080, 16'h0080, 16'h0000, 1'b1);
        @(posedge clk); #1;
        check("rst_after_e14", 16'h0080, 16'h0000, 16'h0000, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
